// File: rtl/ztex_bus_pkg.sv
// Shared definitions for the ZTEX bus master: FSM encoding, default strobe timing
// and the layout of the 128-bit result record.
package ztex_bus_pkg;

  localparam int RESULT_BYTES = 16;

  localparam int DEF_WORK_BYTES = 76;
  localparam int DEF_SETUP_CYC  = 2;
  localparam int DEF_HOLD_CYC   = 6;
  localparam int DEF_START_CYC  = 4;
  localparam int DEF_SETTLE_CYC = 10;
  localparam int DEF_BYTE_CYC   = 8;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_W_SETUP  = 3'd1;
  localparam logic [2:0] S_W_HOLD   = 3'd2;
  localparam logic [2:0] S_R_START  = 3'd3;
  localparam logic [2:0] S_R_SETTLE = 3'd4;
  localparam logic [2:0] S_R_SAMPLE = 3'd5;
  localparam logic [2:0] S_R_WAIT   = 3'd6;

  localparam int GOLDEN_NONCE_A_LSB = 0;
  localparam int NONCE_LSB          = 32;
  localparam int HASH_LSB           = 64;
  localparam int GOLDEN_NONCE_B_LSB = 96;

  // First member lands in the top 32 bits, matching the LSB offsets above.
  typedef struct packed {
    logic [31:0] golden_nonce_b;
    logic [31:0] hash;
    logic [31:0] nonce;
    logic [31:0] golden_nonce_a;
  } result_rec_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ztex_bus_timer.sv
// Loadable down-counter with a zero flag; one instance paces every wait state.
module ztex_bus_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/ztex_bus_master.sv
// Host-side master for the byte-wide ZTEX miner bus: toggle-strobed work download
// and toggle-strobed result upload, one transaction at a time.
module ztex_bus_master
  import ztex_bus_pkg::*;
#(
  parameter int WORK_BYTES = DEF_WORK_BYTES,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int START_CYC  = DEF_START_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int BYTE_CYC   = DEF_BYTE_CYC
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WORK_BYTES*8-1:0]   work_data,
  input  logic                      work_valid,
  output logic                      work_ready,
  input  logic                      result_req,
  output logic [RESULT_BYTES*8-1:0] result_data,
  output logic                      result_valid,
  output logic                      busy,
  output logic                      bus_select,
  output logic [7:0]                bus_read,
  output logic                      bus_rd_clk,
  output logic                      bus_wr_start,
  output logic                      bus_wr_clk,
  input  logic [7:0]                bus_write
);

  localparam int TMAX = max2(max2(max2(SETUP_CYC, HOLD_CYC), max2(START_CYC, SETTLE_CYC)),
                             BYTE_CYC);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = $clog2(max2(WORK_BYTES, RESULT_BYTES) + 1);
  localparam int WW   = WORK_BYTES * 8;
  localparam int RW   = RESULT_BYTES * 8;

  // A wait state lasts N cycles when the timer is loaded with N-1 on entry.
  localparam logic [TW-1:0] LD_SETUP  = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] LD_HOLD   = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] LD_START  = TW'(START_CYC - 1);
  localparam logic [TW-1:0] LD_SETTLE = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] LD_BYTE   = TW'(BYTE_CYC - 1);

  localparam logic [CW-1:0] LAST_WORK   = CW'(WORK_BYTES - 1);
  localparam logic [CW-1:0] LAST_RESULT = CW'(RESULT_BYTES - 1);

  logic [2:0]    state_reg, state_next;
  logic [WW-1:0] work_sr_reg, work_sr_next;
  logic [RW-1:0] res_sr_reg, res_sr_next;
  logic [RW-1:0] result_reg, result_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          valid_reg, valid_next;
  logic          rd_clk_reg, rd_clk_next;
  logic          wr_clk_reg, wr_clk_next;
  logic          ready_reg, ready_next;

  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_zero;

  ztex_bus_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (tmr_load),
    .load_value(tmr_value),
    .zero      (tmr_zero)
  );

  always_comb begin
    state_next   = state_reg;
    work_sr_next = work_sr_reg;
    res_sr_next  = res_sr_reg;
    result_next  = result_reg;
    cnt_next     = cnt_reg;
    valid_next   = 1'b0;
    rd_clk_next  = rd_clk_reg;
    wr_clk_next  = wr_clk_reg;
    tmr_load     = 1'b0;
    tmr_value    = '0;

    case (state_reg)
      S_IDLE: begin
        if (ready_reg) begin
          if (work_valid) begin
            work_sr_next = work_data;
            cnt_next     = '0;
            tmr_load     = 1'b1;
            tmr_value    = LD_SETUP;
            state_next   = S_W_SETUP;
          end else if (result_req) begin
            cnt_next   = '0;
            tmr_load   = 1'b1;
            tmr_value  = LD_START;
            state_next = S_R_START;
          end
        end
      end
      S_W_SETUP: begin
        if (tmr_zero) begin
          rd_clk_next = ~rd_clk_reg;
          tmr_load    = 1'b1;
          tmr_value   = LD_HOLD;
          state_next  = S_W_HOLD;
        end
      end
      S_W_HOLD: begin
        if (tmr_zero) begin
          work_sr_next = work_sr_reg >> 8;
          cnt_next     = cnt_reg + 1'b1;
          if (cnt_reg == LAST_WORK) begin
            state_next = S_IDLE;
          end else begin
            tmr_load   = 1'b1;
            tmr_value  = LD_SETUP;
            state_next = S_W_SETUP;
          end
        end
      end
      S_R_START: begin
        if (tmr_zero) begin
          tmr_load   = 1'b1;
          tmr_value  = LD_SETTLE;
          state_next = S_R_SETTLE;
        end
      end
      S_R_SETTLE: begin
        if (tmr_zero) begin
          state_next = S_R_SAMPLE;
        end
      end
      S_R_SAMPLE: begin
        res_sr_next = {bus_write, res_sr_reg[RW-1:8]};
        cnt_next    = cnt_reg + 1'b1;
        // The final byte needs no strobe, so only RESULT_BYTES-1 toggles occur.
        if (cnt_reg == LAST_RESULT) begin
          result_next = {bus_write, res_sr_reg[RW-1:8]};
          valid_next  = 1'b1;
          state_next  = S_IDLE;
        end else begin
          wr_clk_next = ~wr_clk_reg;
          tmr_load    = 1'b1;
          tmr_value   = LD_BYTE;
          state_next  = S_R_WAIT;
        end
      end
      S_R_WAIT: begin
        if (tmr_zero) begin
          state_next = S_R_SAMPLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    ready_next = (state_next == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      work_sr_reg <= '0;
      res_sr_reg  <= '0;
      result_reg  <= '0;
      cnt_reg     <= '0;
      valid_reg   <= 1'b0;
      rd_clk_reg  <= 1'b0;
      wr_clk_reg  <= 1'b0;
      ready_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      work_sr_reg <= work_sr_next;
      res_sr_reg  <= res_sr_next;
      result_reg  <= result_next;
      cnt_reg     <= cnt_next;
      valid_reg   <= valid_next;
      rd_clk_reg  <= rd_clk_next;
      wr_clk_reg  <= wr_clk_next;
      ready_reg   <= ready_next;
    end
  end

  assign work_ready   = ready_reg;
  assign result_data  = result_reg;
  assign result_valid = valid_reg;
  assign busy         = (state_reg != S_IDLE);
  assign bus_select   = (state_reg != S_IDLE);
  assign bus_read     = ((state_reg == S_W_SETUP) || (state_reg == S_W_HOLD)) ?
                        work_sr_reg[7:0] : 8'h00;
  assign bus_rd_clk   = rd_clk_reg;
  assign bus_wr_start = (state_reg == S_R_START);
  assign bus_wr_clk   = wr_clk_reg;

endmodule
